// File: rtl/imm_encoder.sv
// -----------------------------------------------------------------------------
// imm_encoder
//
// Packs a 32-bit byte-unit immediate into the immediate fields of an RV32I
// instruction word. This is the inverse of the core's immediate generator. It
// sits in the debug/boot patching path, where it builds trampolines and fixes
// up branch offsets before words are written to instruction memory.
//
// Packing and range checking are purely combinational on the request. The
// result is captured into a 2-entry output buffer.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset; empties the buffer, clears the
//              error counter and zeroes the head entry
//   in_valid   request valid
//   in_ready   block can accept a request (registered: count < DEPTH)
//   in_fmt     0 I, 1 S, 2 B, 3 U, 4 J, 5 I-shift, 6/7 reserved
//   in_imm     immediate in bytes, two's complement
//   in_base    base instruction; every non-immediate bit passes through
//   out_valid  head entry valid
//   out_ready  consumer accepts the head entry
//   out_inst   packed instruction (head entry; holds its value when empty)
//   out_err    immediate not representable in the format, or reserved format
//   err_count  saturating count of accepted requests that carried err=1
//
// Handshake: a transfer happens on a rising edge where valid && ready are
// both high. in_ready is a register and has no combinational path from
// out_ready. While out_valid && !out_ready, out_inst and out_err hold steady.
//
// Optional build macro: IMM_ENCODER_ROUNDTRIP_CHECK_EN
//   When it is defined, each packed word is decoded again with the ISA
//   sign-extension rule for its format and compared against in_imm. A
//   mismatch forces err=1. This check is redundant with the range rules, so
//   any disagreement means the packing logic is broken. Ports and timing are
//   the same in both builds.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module imm_encoder #(
   parameter int ERRCNT_W = 8,
   parameter int DEPTH    = 2   // output buffer entries; only 2 is supported
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [2:0]          in_fmt,
   input  logic [31:0]         in_imm,
   input  logic [31:0]         in_base,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [31:0]         out_inst,
   output logic                out_err,
   output logic [ERRCNT_W-1:0] err_count
);

   localparam logic [2:0] FMT_I  = 3'd0;
   localparam logic [2:0] FMT_S  = 3'd1;
   localparam logic [2:0] FMT_B  = 3'd2;
   localparam logic [2:0] FMT_U  = 3'd3;
   localparam logic [2:0] FMT_J  = 3'd4;
   localparam logic [2:0] FMT_SH = 3'd5;

   // ---------------------------------------------------------------------------
   // Range detection. An immediate fits a signed N-bit field exactly when all
   // bits from N-1 upward equal the sign bit, meaning that slice is all ones
   // or all zeros.
   // ---------------------------------------------------------------------------
   logic hi11_mixed;   // does not fit signed 12 bits (I, S)
   logic hi12_mixed;   // does not fit signed 13 bits (B)
   logic hi20_mixed;   // does not fit signed 21 bits (J)

   assign hi11_mixed = ~((&in_imm[31:11]) | (~|in_imm[31:11]));
   assign hi12_mixed = ~((&in_imm[31:12]) | (~|in_imm[31:12]));
   assign hi20_mixed = ~((&in_imm[31:20]) | (~|in_imm[31:20]));

   // ---------------------------------------------------------------------------
   // Field packing. Start from the base word and overwrite only the immediate
   // fields of the selected format. On a range error the truncated bits are
   // still packed, so a caller that ignores err gets the low-order encoding.
   // ---------------------------------------------------------------------------
   logic [31:0] pack_inst;
   logic        range_err;
   logic        new_err;

   always_comb begin
      pack_inst = in_base;
      range_err = 1'b0;
      case (in_fmt)
         FMT_I: begin
            pack_inst[31:20] = in_imm[11:0];
            range_err        = hi11_mixed;
         end
         FMT_S: begin
            pack_inst[31:25] = in_imm[11:5];
            pack_inst[11:7]  = in_imm[4:0];
            range_err        = hi11_mixed;
         end
         FMT_B: begin
            pack_inst[31]    = in_imm[12];
            pack_inst[30:25] = in_imm[10:5];
            pack_inst[11:8]  = in_imm[4:1];
            pack_inst[7]     = in_imm[11];
            range_err        = hi12_mixed | in_imm[0];
         end
         FMT_U: begin
            pack_inst[31:12] = in_imm[31:12];
            range_err        = |in_imm[11:0];
         end
         FMT_J: begin
            pack_inst[31]    = in_imm[20];
            pack_inst[30:21] = in_imm[10:1];
            pack_inst[20]    = in_imm[11];
            pack_inst[19:12] = in_imm[19:12];
            range_err        = hi20_mixed | in_imm[0];
         end
         FMT_SH: begin
            // Bits 31:25 hold funct7 (SRLI vs SRAI) and stay as in the base.
            pack_inst[24:20] = in_imm[4:0];
            range_err        = |in_imm[31:5];
         end
         default: begin
            // Reserved format: the base passes through untouched and is flagged.
            range_err = 1'b1;
         end
      endcase
   end

`ifdef IMM_ENCODER_ROUNDTRIP_CHECK_EN
   // Decode the packed word the way the core's immediate generator would, and
   // compare the result with the original immediate.
   logic [31:0] rt_imm;
   logic        rt_bad;

   always_comb begin
      rt_imm = in_imm;
      case (in_fmt)
         FMT_I:  rt_imm = {{20{pack_inst[31]}}, pack_inst[31:20]};
         FMT_S:  rt_imm = {{20{pack_inst[31]}}, pack_inst[31:25], pack_inst[11:7]};
         FMT_B:  rt_imm = {{19{pack_inst[31]}}, pack_inst[31], pack_inst[7],
                           pack_inst[30:25], pack_inst[11:8], 1'b0};
         FMT_U:  rt_imm = {pack_inst[31:12], 12'h000};
         FMT_J:  rt_imm = {{11{pack_inst[31]}}, pack_inst[31], pack_inst[19:12],
                           pack_inst[20], pack_inst[30:21], 1'b0};
         FMT_SH: rt_imm = {27'd0, pack_inst[24:20]};
         default: rt_imm = in_imm;  // reserved formats are already flagged
      endcase
   end

   assign rt_bad  = (rt_imm != in_imm);
   assign new_err = range_err | rt_bad;
`else
   assign new_err = range_err;
`endif

   // ---------------------------------------------------------------------------
   // Two-entry output buffer. The head register drives the outputs directly,
   // which is why out_inst/out_err keep their last value when the buffer
   // drains. The tail register is used only when two entries are held.
   // ---------------------------------------------------------------------------
   logic [1:0]          count;
   logic [1:0]          count_nxt;
   logic                in_ready_q;
   logic [31:0]         head_inst;
   logic                head_err;
   logic [31:0]         tail_inst;
   logic                tail_err;
   logic [ERRCNT_W-1:0] err_cnt;
   logic                push;
   logic                pop;

   assign push = in_valid & in_ready_q;
   assign pop  = (count != 2'd0) & out_ready;

   always_comb begin
      count_nxt = count;
      case ({push, pop})
         2'b10:   count_nxt = count + 2'd1;
         2'b01:   count_nxt = count - 2'd1;
         default: count_nxt = count;   // idle, or replace-in-place at count 1
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count      <= 2'd0;
         in_ready_q <= 1'b1;
         head_inst  <= 32'd0;
         head_err   <= 1'b0;
         tail_inst  <= 32'd0;
         tail_err   <= 1'b0;
         err_cnt    <= '0;
      end else begin
         count <= count_nxt;
         // Taking ready from the next count keeps throughput at one per cycle
         // without a combinational path from out_ready.
         in_ready_q <= (count_nxt < 2'(DEPTH));

         case ({push, pop})
            2'b10: begin
               if (count == 2'd0) begin
                  head_inst <= pack_inst;
                  head_err  <= new_err;
               end else begin
                  tail_inst <= pack_inst;
                  tail_err  <= new_err;
               end
            end
            2'b01: begin
               // With two entries the tail moves up. With one entry the head
               // keeps its value so the outputs hold while empty.
               if (count == 2'd2) begin
                  head_inst <= tail_inst;
                  head_err  <= tail_err;
               end
            end
            2'b11: begin
               // Only reachable at count 1: at count 2 in_ready is low, and at
               // count 0 there is nothing to pop. The new entry replaces the
               // departing head.
               head_inst <= pack_inst;
               head_err  <= new_err;
            end
            default: ;
         endcase

         if (push && new_err && (err_cnt != {ERRCNT_W{1'b1}}))
            err_cnt <= err_cnt + ERRCNT_W'(1);
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = (count != 2'd0);
   assign out_inst  = head_inst;
   assign out_err   = head_err;
   assign err_count = err_cnt;

endmodule
